// File: rtl/avr_cmd_sequencer.sv
// Command sequencer for the CPLD command muxer: expands AVR-side requests into
// one avr_ctrl code per clock, after an init sequence that parks all latched lines.
module avr_cmd_sequencer #(
  parameter int ADDR_W     = 24,
  parameter int WE_PULSE   = 2,
  parameter int OE_WAIT    = 3,
  parameter int RST_CYCLES = 4
) (
  input  logic              avr_clk,
  input  logic              avr_reset_n,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_arg,
  output logic              cmd_ready,
  output logic [7:0]        avr_ctrl,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_strobe,
  output logic [2:0]        dbg_state
);

  // Handshake: a request is taken on any rising edge where cmd_valid && cmd_ready;
  // op/addr/arg are captured there, and cmd_valid is ignored while cmd_ready is low.

  typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [7:0] C_IDLE     = 8'h01, C_RESET_LO = 8'h02, C_RESET_HI = 8'h03;
  localparam logic [7:0] C_SREG_LO  = 8'h04, C_SREG_HI  = 8'h05;
  localparam logic [7:0] C_SI_LO    = 8'h06, C_SI_HI    = 8'h07;
  localparam logic [7:0] C_OE_LO    = 8'h08, C_OE_HI    = 8'h09;
  localparam logic [7:0] C_WE_LO    = 8'h0A, C_WE_HI    = 8'h0C;
  localparam logic [7:0] C_CNT_LO   = 8'h0D, C_CNT_HI   = 8'h0E;
  localparam logic [7:0] C_MODE_LO  = 8'h0F, C_MODE_HI  = 8'h10;

  localparam logic [2:0] OP_LOAD = 3'd0, OP_WRITE = 3'd1, OP_READ = 3'd2;
  localparam logic [2:0] OP_SRST = 3'd3, OP_MODE = 3'd4;

  localparam int MAX_AW  = (ADDR_W > WE_PULSE) ? ADDR_W : WE_PULSE;
  localparam int MAX_OR  = (OE_WAIT > RST_CYCLES) ? OE_WAIT : RST_CYCLES;
  localparam int MAX_ALL = (MAX_AW > MAX_OR) ? MAX_AW : MAX_OR;
  localparam int CW_RAW  = $clog2(MAX_ALL + 3);
  // At least 3 bits so the five-step init sequence always fits.
  localparam int CW      = (CW_RAW < 3) ? 3 : CW_RAW;

  state_t            state_q, state_d;
  logic [CW-1:0]     step_q, step_d, last_step;
  logic [2:0]        op_q;
  logic              arg_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        ctrl_q, ctrl_d;
  logic              accept, illegal_in;

  assign accept     = cmd_valid && (state_q == S_IDLE || state_q == S_DONE);
  assign illegal_in = (cmd_op > OP_MODE);

  function automatic logic [7:0] code_for(state_t st, logic [2:0] op, logic arg,
                                          logic [ADDR_W-1:0] addr, logic [CW-1:0] step);
    logic [ADDR_W-1:0] sh;
    logic [7:0]        c;
    c  = C_IDLE;
    // Address is shifted MSB first; step 1 carries bit ADDR_W-1.
    sh = addr << (step - CW'(1));
    if (st == S_INIT) begin
      if      (step == CW'(0)) c = C_WE_HI;
      else if (step == CW'(1)) c = C_OE_HI;
      else if (step == CW'(2)) c = C_SREG_HI;
      else if (step == CW'(3)) c = C_CNT_HI;
      else                     c = C_RESET_LO;
    end else if (st == S_RUN) begin
      case (op)
        OP_LOAD: begin
          if      (step == CW'(0))          c = C_SREG_LO;
          else if (step == CW'(ADDR_W + 1)) c = C_SREG_HI;
          else                              c = sh[ADDR_W-1] ? C_SI_HI : C_SI_LO;
        end
        OP_WRITE: begin
          if      (step <  CW'(WE_PULSE))     c = C_WE_LO;
          else if (step == CW'(WE_PULSE))     c = C_WE_HI;
          else if (step == CW'(WE_PULSE + 1)) c = C_CNT_LO;
          else                                c = C_CNT_HI;
        end
        OP_READ: begin
          if      (step <  CW'(OE_WAIT))     c = C_OE_LO;
          else if (step == CW'(OE_WAIT))     c = C_OE_HI;
          else if (step == CW'(OE_WAIT + 1)) c = C_CNT_LO;
          else                               c = C_CNT_HI;
        end
        OP_SRST: c = (step < CW'(RST_CYCLES)) ? C_RESET_HI : C_RESET_LO;
        OP_MODE: c = arg ? C_MODE_HI : C_MODE_LO;
        default: c = C_IDLE;
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge avr_clk) begin
    if (!avr_reset_n) begin
      state_q <= S_RESET;
      step_q  <= '0;
      ctrl_q  <= C_IDLE;
      op_q    <= '0;
      arg_q   <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ctrl_q  <= ctrl_d;
      if (accept) begin
        op_q   <= cmd_op;
        arg_q  <= cmd_arg;
        addr_q <= cmd_addr;
        err_q  <= illegal_in;
      end
    end
  end

  always_comb begin
    last_step = '0;
    case (op_q)
      OP_LOAD:  last_step = CW'(ADDR_W + 1);
      OP_WRITE: last_step = arg_q ? CW'(WE_PULSE + 2) : CW'(WE_PULSE);
      OP_READ:  last_step = arg_q ? CW'(OE_WAIT + 2) : CW'(OE_WAIT);
      OP_SRST:  last_step = CW'(RST_CYCLES);
      default:  last_step = '0;
    endcase

    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_RESET: begin
        state_d = S_INIT;
        step_d  = '0;
      end
      S_INIT: begin
        if (step_q == CW'(4)) begin
          state_d = S_DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      S_IDLE, S_DONE: begin
        step_d = '0;
        if (accept)                 state_d = illegal_in ? S_DONE : S_RUN;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_RUN: begin
        if (step_q == last_step) begin
          state_d = S_DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      default: begin
        state_d = S_RESET;
        step_d  = '0;
      end
    endcase
  end

  always_comb begin
    // Code for the coming cycle uses the request being accepted, if any.
    ctrl_d    = code_for(state_d, accept ? cmd_op : op_q, accept ? cmd_arg : arg_q,
                         accept ? cmd_addr : addr_q, step_d);
    cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    busy      = (state_q == S_RESET) || (state_q == S_INIT) || (state_q == S_RUN);
    done      = (state_q == S_DONE);
    err       = (state_q == S_DONE) && err_q;
    rd_strobe = (state_q == S_RUN) && (op_q == OP_READ) && (step_q == CW'(OE_WAIT - 1));
  end

  assign avr_ctrl  = ctrl_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_avr_cmd_sequencer.sv
// Directed bench for avr_cmd_sequencer with default parameters; every cycle's
// outputs are compared against hand-derived codes and flags.
module tb_avr_cmd_sequencer;

  logic        avr_clk;
  logic        avr_reset_n;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic        cmd_arg;
  logic        cmd_ready;
  logic [7:0]  avr_ctrl;
  logic        busy, done, err, rd_strobe;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  avr_cmd_sequencer #(.ADDR_W(24), .WE_PULSE(2), .OE_WAIT(3), .RST_CYCLES(4)) dut (
    .avr_clk    (avr_clk),
    .avr_reset_n(avr_reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_arg    (cmd_arg),
    .cmd_ready  (cmd_ready),
    .avr_ctrl   (avr_ctrl),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rd_strobe  (rd_strobe),
    .dbg_state  (dbg_state)
  );

  initial avr_clk = 1'b0;
  always #5 avr_clk = ~avr_clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge avr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ctrl code, busy, ready, done, err, rd_strobe for one cycle
  task automatic cyc(input string tag, input logic [7:0] c, input logic b, input logic r,
                     input logic d, input logic e, input logic s);
    chk({tag, ".ctrl"},  avr_ctrl, c);
    chk({tag, ".busy"},  {7'd0, busy}, {7'd0, b});
    chk({tag, ".ready"}, {7'd0, cmd_ready}, {7'd0, r});
    chk({tag, ".done"},  {7'd0, done}, {7'd0, d});
    chk({tag, ".err"},   {7'd0, err}, {7'd0, e});
    chk({tag, ".rds"},   {7'd0, rd_strobe}, {7'd0, s});
  endtask

  task automatic run_init(input string tag);
    logic [7:0] init_codes [5];
    init_codes = '{8'h0C, 8'h09, 8'h05, 8'h0E, 8'h02};
    for (int i = 0; i < 5; i++) begin
      tick();
      cyc($sformatf("%s_init%0d", tag, i), init_codes[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    cyc({tag, "_init_done"}, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp_addr;
    logic [7:0]  wr_codes [5];
    logic [7:0]  rd_codes [4];
    logic        rd_stb   [4];

    avr_reset_n = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 3'd0;
    cmd_addr    = '0;
    cmd_arg     = 1'b0;

    // Reset held
    tick(); tick(); tick();
    cyc("reset", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Release: this is the first cycle after release, still in reset state
    avr_reset_n = 1'b1;
    run_init("boot");
    tick();
    cyc("idle", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // LOAD_ADDR 0xA50001; inputs change after acceptance must be ignored
    exp_addr  = 24'hA50001;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr = exp_addr;
    tick();
    cmd_valid = 1'b0; cmd_addr = 24'h5AFFFE; cmd_op = 3'd3;
    cyc("ld_sreg_lo", 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 23; i >= 0; i--) begin
      tick();
      cyc($sformatf("ld_bit%0d", i), exp_addr[i] ? 8'h07 : 8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    cyc("ld_sreg_hi", 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cyc("ld_done", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    cyc("ld_idle", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // WRITE with auto-increment
    wr_codes  = '{8'h0A, 8'h0A, 8'h0C, 8'h0D, 8'h0E};
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_arg = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_arg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      cyc($sformatf("wr%0d", i), wr_codes[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    cyc("wr_done", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // READ without increment, issued back-to-back in DONE
    rd_codes  = '{8'h08, 8'h08, 8'h08, 8'h09};
    rd_stb    = '{1'b0, 1'b0, 1'b1, 1'b0};
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_arg = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      cyc($sformatf("rd%0d", i), rd_codes[i], 1'b1, 1'b0, 1'b0, 1'b0, rd_stb[i]);
    end
    tick();
    cyc("rd_done", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    cyc("rd_idle", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // MODE=1 with valid held; SNES_RESET taken in the DONE cycle
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_arg = 1'b1;
    tick();
    cmd_op = 3'd3; cmd_arg = 1'b0;
    cyc("mode_hi", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cyc("mode_done", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      cmd_valid = ~cmd_valid; cmd_op = 3'd6;
      cyc($sformatf("srst_hi%0d", i), 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick();
    cmd_valid = 1'b0;
    cyc("srst_lo", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cyc("srst_done", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // Illegal op: straight to DONE with err
    cmd_valid = 1'b1; cmd_op = 3'd6;
    tick();
    cmd_valid = 1'b0;
    cyc("illegal_done", 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    cyc("illegal_idle", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // MODE=0
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_arg = 1'b0;
    tick();
    cmd_valid = 1'b0;
    cyc("mode_lo", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cyc("mode_lo_done", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // Reset during the second WE_LO cycle
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_arg = 1'b0;
    tick();
    cmd_valid = 1'b0;
    cyc("rw_we0", 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cyc("rw_we1", 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    avr_reset_n = 1'b0;
    tick();
    cyc("rw_rst0", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cyc("rw_rst1", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    avr_reset_n = 1'b1;
    run_init("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avr_cmd_sequencer.md
# avr_cmd_sequencer

Sequencer that drives the 8-bit `avr_ctrl` command bus of the CPLD command muxer, one command code per clock. It turns high-level requests (load address, write, read, reset SNES, set mode) into the exact command sequences that shift the address register and strobe the SRAM and counter lines. After reset it first runs a fixed init sequence that puts every latched control line into its inactive level. It sits between the AVR-side request logic and the command muxer.

## Interface

Parameters:
- `ADDR_W`, 24, number of address bits shifted into the serial address register (≥1).
- `WE_PULSE`, 2, number of cycles `WE_LO` is held (≥1).
- `OE_WAIT`, 3, number of cycles `OE_LO` is held before data capture (≥1).
- `RST_CYCLES`, 4, number of cycles `RESET_HI` is held (≥1).

Ports:
- `avr_clk`  in  1  sole clock; all logic on the rising edge.
- `avr_reset_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  request present.
- `cmd_op`  in  3  operation code:
  - 0 = LOAD_ADDR
  - 1 = WRITE
  - 2 = READ
  - 3 = SNES_RESET
  - 4 = MODE
  - 5–7 = illegal
- `cmd_addr`  in  ADDR_W  address for LOAD_ADDR.
- `cmd_arg`  in  1  auto-increment enable for WRITE/READ; mode value for MODE.
- `cmd_ready`  out  1  sequencer can accept a request.
- `avr_ctrl`  out  8  registered command code to the muxer.
- `busy`  out  1  sequence in progress, including init.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `err`  out  1  one-cycle pulse, coincident with `done`, for an illegal op.
- `rd_strobe`  out  1  one-cycle data-capture pulse during READ.

## Operation

- Command codes:
  - IDLE=0x01
  - RESET_LO=0x02, RESET_HI=0x03
  - SREG_EN_LO=0x04, SREG_EN_HI=0x05
  - SI_LO=0x06, SI_HI=0x07
  - OE_LO=0x08, OE_HI=0x09
  - WE_LO=0x0A, WE_HI=0x0C
  - COUNTER_LO=0x0D, COUNTER_HI=0x0E
  - SNES_MODE_LO=0x0F, SNES_MODE_HI=0x10
- States: RESET, INIT, IDLE, RUN, DONE.
- While `avr_reset_n`=0: `avr_ctrl`=0x01, `busy`=1, `cmd_ready`=0, `done`=`err`=`rd_strobe`=0.
- INIT runs on the first cycle after reset is released. It emits WE_HI, OE_HI, SREG_EN_HI, COUNTER_HI, RESET_LO, one per cycle, then goes to DONE.
- A request is accepted on an edge where `cmd_valid`&`cmd_ready`=1.
  - `cmd_op`, `cmd_addr` and `cmd_arg` are captured at that edge; later changes are ignored.
  - `cmd_valid` is ignored while `cmd_ready`=0.
- Sequences, one code per cycle:
  - LOAD_ADDR: SREG_EN_LO; then SI_HI or SI_LO for each of the ADDR_W bits of `cmd_addr`, MSB first; then SREG_EN_HI. Total ADDR_W+2 cycles.
  - WRITE: WE_LO ×WE_PULSE, WE_HI; if `cmd_arg`=1, then COUNTER_LO, COUNTER_HI.
  - READ: OE_LO ×OE_WAIT, with `rd_strobe`=1 in the last OE_LO cycle; then OE_HI; if `cmd_arg`=1, then COUNTER_LO, COUNTER_HI.
  - SNES_RESET: RESET_HI ×RST_CYCLES, RESET_LO.
  - MODE: one cycle of SNES_MODE_HI if `cmd_arg`=1, else SNES_MODE_LO.
  - Illegal op: no codes emitted; goes straight to DONE with `err`=1.
- DONE lasts one cycle: `avr_ctrl`=0x01, `done`=1, `busy`=0, `cmd_ready`=1. It then goes to IDLE, or to RUN if a request is accepted in this cycle.
- In IDLE: `avr_ctrl`=0x01, `cmd_ready`=1, `busy`=0.
- Internal counters are wide enough for max(ADDR_W, WE_PULSE, OE_WAIT, RST_CYCLES)+2 without wrap.

## Timing

- Request accepted at edge A. The first sequence code is on `avr_ctrl` from edge A+1, with `cmd_ready`=0 and `busy`=1.
- If the last code is driven in cycle L, cycle L+1 is DONE.
- Latency from acceptance to `done`:
  - LOAD_ADDR: ADDR_W+3
  - WRITE: WE_PULSE+2, plus 2 with auto-increment
  - READ: OE_WAIT+2, plus 2 with auto-increment
  - SNES_RESET: RST_CYCLES+2
  - MODE: 2
  - Illegal: 1
- Back-to-back: a request accepted in DONE starts its first code on the next cycle, with no IDLE gap.
- Reset mid-sequence, including while WE_LO or OE_LO is being held:
  - `avr_ctrl` is 0x01 on the cycle after reset is sampled low.
  - No `done` pulse is generated.
  - INIT reruns after release, so WE is deasserted first.
- `rd_strobe` is never asserted outside READ. `err` is never asserted without `done`.

## Test plan

- Release reset → `avr_ctrl` = 0x0C, 0x09, 0x05, 0x0E, 0x02, then 0x01 with `done`=1; `cmd_ready`=1 on the DONE cycle (7th cycle after release, counting the release cycle as the first).
- LOAD_ADDR with `ADDR_W`=24, `cmd_addr`=0xA50001 → 0x04; then SI codes 0x07,0x06,0x07,0x06,0x06,0x07,0x06,0x07, followed by 15×0x06 and 0x07; then 0x05. `done` 27 cycles after acceptance.
- WRITE with `cmd_arg`=1, `WE_PULSE`=2 → 0x0A, 0x0A, 0x0C, 0x0D, 0x0E, then DONE. READ with `cmd_arg`=0, `OE_WAIT`=3 → 0x08 ×3 with `rd_strobe` only on the third cycle, then 0x09.
- MODE (`cmd_arg`=1) held valid through DONE, followed by SNES_RESET → 0x10, DONE, then immediately 0x03 ×4, 0x02; `cmd_valid` toggling while busy has no effect.
- `cmd_op`=6 → no codes emitted; `done`=`err`=1 one cycle after acceptance.
- Assert reset during the second WE_LO cycle of a WRITE → 0x01 the next cycle; no `done`; after release the init sequence begins with 0x0C.
